mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Load/store unit for the CPU memory stage, directly upstream of the data-cache request port.
- Accepts one load/store per transaction from execute over a valid/ready handshake.
- Checks alignment, generates the word-aligned address, byte enables and lane-replicated store data, then holds the cache request until ready.
- Extracts and sign/zero-extends load data; returns one response (data or fault) to writeback. A watchdog aborts hung bus requests.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of BUS cycles without mem_req_ready_i before fault; 0 disables the watchdog.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid_i  input  1  execute presents an operation.
- req_ready_o  output  1  LSU can accept; high only in IDLE.
- req_we_i  input  1  1 = store, 0 = load.
- req_funct3_i  input  3  RV32 funct3: LB, LH, LW, LBU, LHU / SB, SH, SW.
- req_addr_i  input  32  effective byte address.
- req_wdata_i  input  32  store data, right-aligned.
- req_rd_i  input  5  load destination register.
- resp_valid_o  output  1  one-cycle completion pulse.
- resp_data_o  output  32  extended load result; 0 for stores and faults.
- resp_rd_o  output  5  destination register; 0 for stores.
- resp_fault_o  output  1  transaction faulted.
- resp_fault_cause_o  output  2  00 none, 01 misaligned/illegal funct3, 10 timeout.
- mem_req_addr_o  output  32  {addr[31:2],2'b00}.
- mem_req_wdata_o  output  32  lane-replicated store data.
- mem_req_we_o  output  1  write enable.
- mem_req_be_o  output  4  byte enables.
- mem_req_valid_o  output  1  request valid.
- mem_resp_data_i  input  32  read word from cache.
- mem_req_ready_i  input  1  cache completion; may be combinational from bus ack.

Behaviour:
- Reset (rst high at an edge):
  - state IDLE and watchdog counter cleared.
  - All outputs 0, including req_ready_o. req_ready_o rises in the first cycle after rst deasserts.
  - Mid-transaction reset discards the in-flight op; mem_req_valid_o is low from the next cycle and no resp_valid_o is issued.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i && req_ready_o, latch all req_* fields.
  - Illegal/misaligned cases: funct3 011/110/111; store with funct3[2]=1; half access with addr[0]=1; word access with addr[1:0]!=0. Any of these → FAULT, and no mem request is issued.
  - Otherwise → BUS.
- BUS:
  - mem_req_valid_o = 1; addr/wdata/we/be are registered and stable until ready.
  - Byte enables: byte = 0001<<off; half = 0011<<off; word = 1111.
  - Store data: SB replicates the byte ×4; SH replicates the half ×2; SW passes data unchanged.
  - If mem_req_ready_i is high at an edge: capture mem_resp_data_i → RESP.
  - Else increment the counter; if the counter reaches TIMEOUT_CYCLES (when nonzero) → RESP with cause 10.
  - If ready and timeout occur at the same edge, ready wins.
- FAULT: resp_valid_o = 1 with cause 01 for one cycle → IDLE.
- RESP:
  - mem_req_valid_o = 0.
  - resp_valid_o = 1 for exactly one cycle → IDLE.
  - Load lane = word >> (8*off); LB/LH sign-extend, LBU/LHU zero-extend.
- Latency: accept at edge 0; the request is visible in cycle 1. With ready in cycle 1, resp_valid_o is high in cycle 2 and the next accept can happen at edge 3.
- Misaligned ops: accept at edge 0, resp_valid_o high in cycle 1.
- mem_req_ready_i outside BUS is ignored. req_valid_i while busy is ignored; upstream holds its request.
- resp_* outputs are held at 0 whenever resp_valid_o = 0.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants.
  - state enum {IDLE, BUS, FAULT, RESP}.
  - fault-cause enum.
- One combinational sub-module, lsu_load_align: (word, offset, funct3) → extended 32-bit result.

Test Plan:
- LW 0x100, ready in first BUS cycle, rdata 0xDEADBEEF → be=1111, resp_data=0xDEADBEEF, resp_valid in cycle 2.
- LB 0x103, rdata 0x80FF_0000 → be=1000, resp_data=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH 0x202, wdata 0x1234ABCD → addr 0x200, be=1100, wdata=0xABCD_ABCD, we=1, resp_rd=0.
- LW 0x101 → no mem_req_valid_o ever; resp_valid in cycle 1 with fault cause 01. SB funct3=100 → cause 01.
- TIMEOUT_CYCLES=4, ready never asserted → mem_req_valid_o high exactly 4 cycles, then resp fault cause 10. Ready asserted on the 4th cycle → normal completion.
- rst asserted in the 2nd BUS cycle → mem_req_valid_o low the next cycle, no resp_valid, req_ready_o high one cycle after rst drops.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the memory-stage load/store unit.
// Funct3 codes, FSM states, fault causes, plus byte-enable and store-lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, BUS, FAULT, RESP} state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } cause_t;

  function automatic logic access_illegal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    if (we && f3[2]) bad = 1'b1;
    if (f3[1:0] == 2'b01 && off[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && off != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating across lanes lets the cache pick the lane purely by byte enable.
  function automatic logic [31:0] replicate_store(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: shifts the read word down by the byte offset and
// sign- or zero-extends according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0]        shifted;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    result  = 32'd0;
    case (funct3)
      F3_LB:   result = 32'(lane_b);
      F3_LH:   result = 32'(lane_h);
      F3_LW:   result = shifted;
      F3_LBU:  result = {24'd0, shifted[7:0]};
      F3_LHU:  result = {16'd0, shifted[15:0]};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: accepts one op, issues a held cache request,
// returns one response (data or fault) and aborts hung requests via a watchdog.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_fault_o,
  output logic [1:0]  resp_fault_cause_o,
  output logic [31:0] mem_req_addr_o,
  output logic [31:0] mem_req_wdata_o,
  output logic        mem_req_we_o,
  output logic [3:0]  mem_req_be_o,
  output logic        mem_req_valid_o,
  input  logic [31:0] mem_resp_data_i,
  input  logic        mem_req_ready_i
);

  state_t      state, state_next;
  cause_t      cause;
  logic [31:0] cnt;
  logic        accept, illegal, timeout_hit;

  logic        op_we;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata, rdata, load_result;
  logic [3:0]  op_be;
  logic [4:0]  op_rd;

  assign accept      = req_valid_i && req_ready_o;
  assign illegal     = access_illegal(req_we_i, req_funct3_i, req_addr_i[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt + 32'd1 == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 32'd0;
      cause <= CAUSE_NONE;
    end else if (accept) begin
      cnt   <= 32'd0;
      cause <= illegal ? CAUSE_MISALIGN : CAUSE_NONE;
    end else if (state == BUS && !mem_req_ready_i) begin
      cnt <= cnt + 32'd1;
      if (timeout_hit) cause <= CAUSE_TIMEOUT;
    end
  end

  // Operand and read-data capture; control state alone carries reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_we     <= req_we_i;
      op_funct3 <= req_funct3_i;
      op_addr   <= req_addr_i;
      op_rd     <= req_rd_i;
      op_be     <= byte_enables(req_funct3_i, req_addr_i[1:0]);
      op_wdata  <= replicate_store(req_funct3_i, req_wdata_i);
    end
    if (state == BUS && mem_req_ready_i) rdata <= mem_resp_data_i;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = illegal ? FAULT : BUS;
      BUS:     if (mem_req_ready_i || timeout_hit) state_next = RESP;
      FAULT:   state_next = IDLE;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lsu_load_align u_align (
    .word   (rdata),
    .offset (op_addr[1:0]),
    .funct3 (op_funct3),
    .result (load_result)
  );

  always_comb begin
    req_ready_o        = (state == IDLE) && !rst;
    resp_valid_o       = 1'b0;
    resp_data_o        = 32'd0;
    resp_rd_o          = 5'd0;
    resp_fault_o       = 1'b0;
    resp_fault_cause_o = CAUSE_NONE;
    mem_req_addr_o     = 32'd0;
    mem_req_wdata_o    = 32'd0;
    mem_req_we_o       = 1'b0;
    mem_req_be_o       = 4'd0;
    mem_req_valid_o    = 1'b0;
    case (state)
      BUS: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {op_addr[31:2], 2'b00};
        mem_req_wdata_o = op_wdata;
        mem_req_we_o    = op_we;
        mem_req_be_o    = op_be;
      end
      FAULT: begin
        resp_valid_o       = 1'b1;
        resp_fault_o       = 1'b1;
        resp_fault_cause_o = CAUSE_MISALIGN;
        resp_rd_o          = op_we ? 5'd0 : op_rd;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_rd_o    = op_we ? 5'd0 : op_rd;
        if (cause == CAUSE_TIMEOUT) begin
          resp_fault_o       = 1'b1;
          resp_fault_cause_o = CAUSE_TIMEOUT;
        end else if (!op_we) begin
          resp_data_o = load_result;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table for single transactions,
// plus hand-written sequences for watchdog and mid-transaction reset.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_cause;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_valid, mem_ready;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_we_i           (req_we),
    .req_funct3_i       (req_funct3),
    .req_addr_i         (req_addr),
    .req_wdata_i        (req_wdata),
    .req_rd_i           (req_rd),
    .resp_valid_o       (resp_valid),
    .resp_data_o        (resp_data),
    .resp_rd_o          (resp_rd),
    .resp_fault_o       (resp_fault),
    .resp_fault_cause_o (resp_cause),
    .mem_req_addr_o     (mem_addr),
    .mem_req_wdata_o    (mem_wdata),
    .mem_req_we_o       (mem_we),
    .mem_req_be_o       (mem_be),
    .mem_req_valid_o    (mem_valid),
    .mem_resp_data_i    (mem_rdata),
    .mem_req_ready_i    (mem_ready)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] data_exp;
    logic [4:0]  rd_exp;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [4:0] rd, logic [31:0] rdata, logic fault, logic [3:0] be,
                              logic [31:0] maddr, logic [31:0] mwdata, logic [31:0] data_exp,
                              logic [4:0] rd_exp);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
    v.fault = fault; v.be = be; v.maddr = maddr; v.mwdata = mwdata;
    v.data_exp = data_exp; v.rd_exp = rd_exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    present(v.we, v.f3, v.addr, v.wdata, v.rd);
    @(negedge clk);
    if (v.fault) begin
      check({tag, "_fault_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_fault_flag"}, 32'(resp_fault), 32'd1);
      check({tag, "_fault_cause"}, 32'(resp_cause), 32'd1);
      check({tag, "_fault_noreq"}, 32'(mem_valid), 32'd0);
      check({tag, "_fault_data"}, resp_data, 32'd0);
    end else begin
      check({tag, "_req_valid"}, 32'(mem_valid), 32'd1);
      check({tag, "_req_addr"}, mem_addr, v.maddr);
      check({tag, "_req_be"}, 32'(mem_be), 32'(v.be));
      check({tag, "_req_we"}, 32'(mem_we), 32'(v.we));
      if (v.we) check({tag, "_req_wdata"}, mem_wdata, v.mwdata);
      check({tag, "_no_early_resp"}, 32'(resp_valid), 32'd0);
      mem_ready = 1'b1; mem_rdata = v.rdata;
      @(posedge clk);
      #1 mem_ready = 1'b0; mem_rdata = 32'hA5A5_5A5A;
      @(negedge clk);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
      check({tag, "_resp_data"}, resp_data, v.data_exp);
      check({tag, "_resp_rd"}, 32'(resp_rd), 32'(v.rd_exp));
      check({tag, "_req_dropped"}, 32'(mem_valid), 32'd0);
    end
    @(negedge clk);
    check({tag, "_resp_single"}, 32'(resp_valid), 32'd0);
    check({tag, "_back_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n;
    int hi_cycles;
    logic done;

    vecs[0]  = mk(0, 3'b010, 32'h100, 0, 5'd5, 32'hDEADBEEF, 0, 4'hF, 32'h100, 0, 32'hDEADBEEF, 5'd5);
    vecs[1]  = mk(0, 3'b000, 32'h103, 0, 5'd6, 32'h80FF0000, 0, 4'h8, 32'h100, 0, 32'hFFFFFF80, 5'd6);
    vecs[2]  = mk(0, 3'b100, 32'h103, 0, 5'd7, 32'h80FF0000, 0, 4'h8, 32'h100, 0, 32'h00000080, 5'd7);
    vecs[3]  = mk(0, 3'b001, 32'h102, 0, 5'd8, 32'h80FF0000, 0, 4'hC, 32'h100, 0, 32'hFFFF80FF, 5'd8);
    vecs[4]  = mk(0, 3'b101, 32'h100, 0, 5'd9, 32'h12348765, 0, 4'h3, 32'h100, 0, 32'h00008765, 5'd9);
    vecs[5]  = mk(0, 3'b000, 32'h101, 0, 5'd10, 32'h00007F00, 0, 4'h2, 32'h100, 0, 32'h0000007F, 5'd10);
    vecs[6]  = mk(1, 3'b001, 32'h202, 32'h1234ABCD, 5'd7, 32'hFFFFFFFF, 0, 4'hC, 32'h200, 32'hABCDABCD, 0, 0);
    vecs[7]  = mk(1, 3'b000, 32'h301, 32'h000000A5, 5'd3, 32'hFFFFFFFF, 0, 4'h2, 32'h300, 32'hA5A5A5A5, 0, 0);
    vecs[8]  = mk(1, 3'b010, 32'h404, 32'hCAFEF00D, 5'd4, 32'h0, 0, 4'hF, 32'h404, 32'hCAFEF00D, 0, 0);
    vecs[9]  = mk(0, 3'b010, 32'h101, 0, 5'd9, 0, 1, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 3'b100, 32'h010, 32'h55, 5'd1, 0, 1, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 3'b001, 32'h103, 0, 5'd2, 0, 1, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 3'b011, 32'h000, 0, 5'd2, 0, 1, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 3'b001, 32'h201, 32'h1, 5'd2, 0, 1, 0, 0, 0, 0, 0);

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Watchdog: ready never asserted, request held exactly TIMEOUT_CYCLES cycles.
    present(1'b0, 3'b010, 32'h500, 32'd0, 5'd11);
    hi_cycles = 0; done = 1'b0; n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_valid) hi_cycles++;
      if (resp_valid) done = 1'b1;
    end
    check("to_resp_seen", 32'(done), 32'd1);
    check("to_valid_cycles", 32'(hi_cycles), 32'd4);
    check("to_fault", 32'(resp_fault), 32'd1);
    check("to_cause", 32'(resp_cause), 32'd2);
    check("to_data", resp_data, 32'd0);
    @(negedge clk);
    check("to_back_idle", 32'(req_ready), 32'd1);

    // Ready arriving in the last allowed cycle completes normally.
    present(1'b0, 3'b010, 32'h504, 32'd0, 5'd12);
    repeat (3) @(negedge clk);
    check("late_valid_c3", 32'(mem_valid), 32'd1);
    @(negedge clk);
    check("late_valid_c4", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h11223344;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    check("late_resp_valid", 32'(resp_valid), 32'd1);
    check("late_resp_fault", 32'(resp_fault), 32'd0);
    check("late_resp_data", resp_data, 32'h11223344);
    check("late_resp_rd", 32'(resp_rd), 32'd12);

    // Reset during the second BUS cycle discards the op.
    @(negedge clk);
    present(1'b0, 3'b010, 32'h600, 32'd0, 5'd13);
    @(negedge clk);
    @(negedge clk);
    check("mrst_bus2_valid", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    check("mrst_valid_low", 32'(mem_valid), 32'd0);
    check("mrst_no_resp", 32'(resp_valid), 32'd0);
    check("mrst_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_ready_back", 32'(req_ready), 32'd1);
    check("mrst_no_resp2", 32'(resp_valid), 32'd0);
    check("mrst_valid_low2", 32'(mem_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
